// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute and writeback, and traps on illegal opcodes or memory wait timeouts.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch_taken,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd15
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] waitCnt_q, waitCnt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic            memState;
  logic            timeoutHit;

  // Only FETCH, MEMREAD and MEMWRITE issue memory requests and can stall.
  assign memState   = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign timeoutHit = (MEM_TIMEOUT != 0) && memState && !mem_ready && (waitCnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = (memState && !mem_ready) ? waitCnt_q + 1'b1 : '0;
    unique case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          default:                state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? FETCH : TRAP;
      JAL:      state_d = ALUWB;
      default:  state_d = TRAP;
    endcase
    // A request that completes on its last allowed cycle is not a timeout.
    if (timeoutHit) state_d = TRAP;
    illegal_d = illegal_q || (state_d == TRAP);
    timeout_d = timeout_q || timeoutHit;
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    pc_update    = 1'b0;
    branch_taken = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    result_src   = 2'b00;
    instr_done   = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        case (funct3)
          3'b000: begin
            branch_taken = zero;
            instr_done   = 1'b1;
          end
          3'b001: begin
            branch_taken = ~zero;
            instr_done   = 1'b1;
          end
          default: ;
        endcase
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule
